// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file and its clear engine.
package rf_pkg;

  // Clear engine states: idle, or sweeping the array one entry per cycle.
  typedef enum logic {RF_IDLE, RF_SWEEP} rf_clr_state_t;

  localparam int RF_DEFAULT_W     = 32;
  localparam int RF_DEFAULT_DEPTH = 32;

  // First entry the sweep touches: entry 0 is skipped when it is hardwired to zero.
  function automatic int rf_first_clr_addr(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Sequential clear engine: walks ptr across the array and zeroes one entry per cycle.
module reg_file_clr_fsm
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(rf_first_clr_addr(ZERO_REG));

  rf_clr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              at_last;

  assign at_last = (ptr_q == LAST);

  // State and sweep pointer registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic; a request during a sweep is ignored and ptr stops at the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_SWEEP;
          ptr_d   = FIRST;
        end
      end
      RF_SWEEP: begin
        if (at_last) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == RF_SWEEP);
  assign clr_done = clr_busy && at_last;
  assign clr_en   = clr_busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, one synchronous write,
// optional write-to-read bypass, optional hardwired zero entry, and a clear sweep.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DEFAULT_W,
  parameter int DEPTH    = RF_DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  reg_file_clr_fsm #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_clr_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  // Storage: one register per entry; entry 0 is a constant when hardwired to zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] q;
      // A write to the entry under the sweep pointer takes priority over the clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (we && (wa == IDX)) begin
          q <= wd;
        end else if (clr_en && (clr_addr == IDX)) begin
          q <= '0;
        end
      end
      assign mem[i] = q;
    end
  end

  // Read ports: array lookup, then same-cycle write forwarding, then the zero entry override.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    assign a = ra[p*ADDR_W +: ADDR_W];
    // Combinational read; the zero entry wins even over a forwarded write.
    always_comb begin
      v = mem[a];
      if (BYPASS != 0 && we && (wa == a)) v = wd;
      if (ZERO_REG != 0 && (a == '0)) v = '0;
    end
    assign rd[p*DATA_W +: DATA_W] = v;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: one default instance (bypass, zero entry, 32 deep)
// and one small instance without bypass or zero entry (8 deep).
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        we1, clr_req1, busy1, done1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [9:0]  ra1;
  logic [63:0] rd1;

  logic        we2, clr_req2, busy2, done2;
  logic [2:0]  wa2;
  logic [31:0] wd2;
  logic [5:0]  ra2;
  logic [63:0] rd2;

  typedef struct {
    logic [127:0] tag;
    int           sel;
    logic [31:0]  exp;
  } chk_t;

  chk_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  int   run1 = 0, last_len1 = 0, done_cnt1 = 0, done_pos1 = 0;
  int   run2 = 0, last_len2 = 0, done_cnt2 = 0, done_pos2 = 0;
  logic pbusy1 = 1'b0, pbusy2 = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd1),
    .clr_req(clr_req1), .clr_busy(busy1), .clr_done(done1)
  );

  reg_file_mp #(
    .DATA_W(32), .DEPTH(8), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2), .rd(rd2),
    .clr_req(clr_req2), .clr_busy(busy2), .clr_done(done2)
  );

  function automatic logic [31:0] sel_val(input int s);
    case (s)
      0:  return rd1[31:0];
      1:  return rd1[63:32];
      2:  return rd2[31:0];
      3:  return rd2[63:32];
      4:  return {31'b0, busy1};
      5:  return {31'b0, done1};
      6:  return {31'b0, busy2};
      7:  return 32'(last_len1);
      8:  return 32'(done_cnt1);
      9:  return 32'(done_pos1);
      10: return 32'(last_len2);
      11: return 32'(done_cnt2);
      12: return 32'(done_pos2);
      13: return {31'b0, done2};
      default: return 32'hDEAD0BAD;
    endcase
  endfunction

  // Monitor: track sweep lengths and done pulses, then drain and compare the scoreboard.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (busy1 === 1'b1) run1++;
      if (done1 === 1'b1) begin done_cnt1++; done_pos1 = run1; end
      if (busy1 !== 1'b1 && pbusy1) begin last_len1 = run1; run1 = 0; end
      pbusy1 = (busy1 === 1'b1);
      if (busy2 === 1'b1) run2++;
      if (done2 === 1'b1) begin done_cnt2++; done_pos2 = run2; end
      if (busy2 !== 1'b1 && pbusy2) begin last_len2 = run2; run2 = 0; end
      pbusy2 = (busy2 === 1'b1);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        act = sel_val(c.sel);
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %0s (sel %0d): got %h expected %h", c.tag, c.sel, act, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [127:0] t, input int s, input logic [31:0] e);
    chk_t c;
    c.tag = t; c.sel = s; c.exp = e;
    sbq.push_back(c);
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    we1 = 1'b1; wa1 = a; wd1 = d;
    tick();
    we1 = 1'b0;
  endtask

  task automatic wr2(input logic [2:0] a, input logic [31:0] d);
    we2 = 1'b1; wa2 = a; wd2 = d;
    tick();
    we2 = 1'b0;
  endtask

  task automatic rdchk1(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [127:0] t);
    ra1 = {a1, a0};
    sb_push(t, 0, e0);
    sb_push(t, 1, e1);
    tick();
  endtask

  task automatic rdchk2(input logic [2:0] a0, input logic [2:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [127:0] t);
    ra2 = {a1, a0};
    sb_push(t, 2, e0);
    sb_push(t, 3, e1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    we1 = 0; wa1 = '0; wd1 = '0; ra1 = '0; clr_req1 = 0;
    we2 = 0; wa2 = '0; wd2 = '0; ra2 = '0; clr_req2 = 0;

    // reset state
    tick();
    ra1 = {5'd0, 5'd5};
    ra2 = {3'd0, 3'd5};
    sb_push("rst_rd1_0", 0, 32'h0);
    sb_push("rst_rd1_1", 1, 32'h0);
    sb_push("rst_rd2_0", 2, 32'h0);
    sb_push("rst_busy1", 4, 32'h0);
    sb_push("rst_done1", 5, 32'h0);
    sb_push("rst_busy2", 6, 32'h0);
    sb_push("rst_done2", 13, 32'h0);
    #1;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL direct rst busy1 = %b", busy1); end
    if (busy2 !== 1'b0) begin bad++; $display("FAIL direct rst busy2 = %b", busy2); end
    if (rd1 !== 64'h0) begin bad++; $display("FAIL direct rst rd1 = %h", rd1); end
    tick();
    rst_n = 1'b1;
    tick();

    // basic write then read; x0 reads zero
    wr1(5'd5, 32'hDEADBEEF);
    rdchk1(5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "wr_x5");

    // same-cycle write/read: forwarded on dut1, old value on dut2
    we1 = 1; wa1 = 5'd7; wd1 = 32'h12345678; ra1 = {5'd5, 5'd7};
    we2 = 1; wa2 = 3'd7; wd2 = 32'h12345678; ra2 = {3'd0, 3'd7};
    sb_push("byp_on", 0, 32'h12345678);
    sb_push("byp_other", 1, 32'hDEADBEEF);
    sb_push("byp_off", 2, 32'h0);
    #1;
    if (rd1[31:0] !== 32'h12345678) begin bad++; $display("FAIL direct byp_on = %h", rd1[31:0]); end
    tick();
    we1 = 0; we2 = 0;
    rdchk2(3'd7, 3'd0, 32'h12345678, 32'h0, "byp_off_next");

    // zero register: write discarded, same-cycle forward suppressed
    we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = {5'd7, 5'd0};
    sb_push("zr_byp", 0, 32'h0);
    sb_push("zr_x7", 1, 32'h12345678);
    tick();
    we1 = 0;
    rdchk1(5'd0, 5'd0, 32'h0, 32'h0, "zr_x0");
    wr2(3'd0, 32'hFFFFFFFF);
    rdchk2(3'd0, 3'd7, 32'hFFFFFFFF, 32'h12345678, "nozr_x0");

    // fill dut1 x1..x31 with their index
    for (int i = 1; i < 32; i++) wr1(5'(i), 32'(i));
    rdchk1(5'd31, 5'd20, 32'd31, 32'd20, "fill");

    // sweep with a collision write, a late write and a repeated request
    clr_req1 = 1;
    tick();                         // ptr = 1
    clr_req1 = 0;
    tick();                         // ptr = 2
    tick();                         // ptr = 3
    we1 = 1; wa1 = 5'd3; wd1 = 32'hA5A5A5A5;
    tick();                         // ptr = 4
    we1 = 0;
    clr_req1 = 1;
    tick();                         // ptr = 5
    clr_req1 = 0;
    for (int k = 0; k < 5; k++) tick();   // ptr = 10
    we1 = 1; wa1 = 5'd20; wd1 = 32'hBEEF0020;
    tick();
    we1 = 0;
    for (int k = 0; k < 64 && busy1; k++) tick();
    sb_push("sweep_end1", 4, 32'h0);
    tick();
    for (int i = 0; i < 32; i += 2)
      rdchk1(5'(i), 5'(i + 1), (i == 3) ? 32'hA5A5A5A5 : 32'h0,
             (i + 1 == 3) ? 32'hA5A5A5A5 : 32'h0, "sweep_rd1");
    sb_push("sweep_len1", 7, 32'd31);
    sb_push("done_cnt1", 8, 32'd1);
    sb_push("done_pos1", 9, 32'd31);
    tick();

    // dut2 sweep covers entry 0 and all DEPTH entries
    for (int i = 0; i < 8; i++) wr2(3'(i), 32'h100 + 32'(i));
    rdchk2(3'd0, 3'd6, 32'h100, 32'h106, "fill2");
    clr_req2 = 1;
    tick();
    clr_req2 = 0;
    for (int k = 0; k < 32 && busy2; k++) tick();
    sb_push("sweep_end2", 6, 32'h0);
    tick();
    for (int i = 0; i < 8; i += 2)
      rdchk2(3'(i), 3'(i + 1), 32'h0, 32'h0, "sweep_rd2");
    sb_push("sweep_len2", 10, 32'd8);
    sb_push("done_cnt2", 11, 32'd1);
    sb_push("done_pos2", 12, 32'd8);
    tick();

    // asynchronous reset in the middle of a sweep
    wr1(5'd10, 32'h55);
    rdchk1(5'd10, 5'd3, 32'h55, 32'hA5A5A5A5, "pre_abort");
    clr_req1 = 1;
    tick();
    clr_req1 = 0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst_n = 1'b0;
    ra1 = {5'd3, 5'd10};
    sb_push("abort_busy", 4, 32'h0);
    sb_push("abort_done", 5, 32'h0);
    sb_push("abort_x10", 0, 32'h0);
    sb_push("abort_x3", 1, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    sb_push("abort_nodone", 8, 32'd1);
    rdchk1(5'd10, 5'd3, 32'h0, 32'h0, "post_abort");

    // a fresh sweep after the abort runs its full length
    clr_req1 = 1;
    tick();
    clr_req1 = 0;
    for (int k = 0; k < 64 && busy1; k++) tick();
    sb_push("sweep_end3", 4, 32'h0);
    tick();
    sb_push("sweep_len3", 7, 32'd31);
    sb_push("done_cnt3", 8, 32'd2);
    tick();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0 || total < 12) begin
      $display("FAIL: %0d mismatches out of %0d checks", bad, total);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
